// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence detector: FSM state encoding and sizing helper.
package seq_det_pkg;

    localparam logic ST_FILL = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    function automatic int clog2_f(input int value);
        int result;
        result = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating event counter with sticky saturation flag and synchronous clear (clear wins over inc).
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;
    logic             sat_r;

    // Count register: clear has priority, then increment-or-saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
            sat_r <= 1'b0;
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
            sat_r <= 1'b0;
        end else if (inc) begin
            if (cnt_r == CNT_MAX) begin
                sat_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
            sat_r <= sat_r;
        end
    end

    assign cnt = cnt_r;
    assign sat = sat_r;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with overlap control and saturating match counter.
// Optional macro SEQ_DET_PROG_EN adds a run-time loadable pattern (pat_wr / pat_in).
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b0110,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             x,
    input  logic             overlap_en,
    input  logic             clr_cnt,
`ifdef SEQ_DET_PROG_EN
    input  logic             pat_wr,
    input  logic [LEN-1:0]   pat_in,
`endif
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int                FILL_W    = clog2_f(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);

    logic              state_r;
    logic              state_nxt_s;
    logic [LEN-1:0]    hist_r;
    logic [LEN-1:0]    hist_nxt_s;
    logic [LEN-1:0]    nh_s;
    logic [LEN-1:0]    pat_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_nxt_s;
    logic [FILL_W-1:0] fill_inc_s;
    logic              load_s;
    logic              hit_s;
    logic              z_r;

`ifdef SEQ_DET_PROG_EN
    logic [LEN-1:0] pat_r;

    // Programmable pattern register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_r <= PATTERN;
        end else if (pat_wr) begin
            pat_r <= pat_in;
        end else begin
            pat_r <= pat_r;
        end
    end

    assign pat_s  = pat_r;
    assign load_s = pat_wr;
`else
    assign pat_s  = PATTERN;
    assign load_s = 1'b0;
`endif

    assign nh_s       = {hist_r[LEN-2:0], x};
    // In RUN the fill count is pinned at LEN, so every valid sample is evaluated.
    assign fill_inc_s = (state_r == ST_RUN) ? fill_r : fill_r + FILL_W'(1);

    // State, history and fill registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FILL;
            hist_r  <= {LEN{1'b0}};
            fill_r  <= {FILL_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            hist_r  <= hist_nxt_s;
            fill_r  <= fill_nxt_s;
        end
    end

    // Next-state logic: shift on valid samples, restart on pattern load or non-overlapping hit.
    always_comb begin
        state_nxt_s = state_r;
        hist_nxt_s  = hist_r;
        fill_nxt_s  = fill_r;
        if (load_s || (hit_s && !overlap_en)) begin
            state_nxt_s = ST_FILL;
            hist_nxt_s  = {LEN{1'b0}};
            fill_nxt_s  = {FILL_W{1'b0}};
        end else if (in_valid) begin
            hist_nxt_s = nh_s;
            fill_nxt_s = fill_inc_s;
            case (state_r)
                ST_FILL: state_nxt_s = (fill_inc_s == FILL_FULL) ? ST_RUN : ST_FILL;
                ST_RUN:  state_nxt_s = ST_RUN;
                default: state_nxt_s = ST_FILL;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output logic: match decision on the current sample.
    always_comb begin
        hit_s = 1'b0;
        if (in_valid && !load_s && (fill_inc_s == FILL_FULL) && (nh_s == pat_s)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Registered match pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_r <= 1'b0;
        end else begin
            z_r <= hit_s;
        end
    end

    assign z = z_r;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit_s),
        .clr (clr_cnt),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule
